// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings and constants for the main-RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int         RAM_AW  = 18;
    localparam logic [3:0] BE_WORD = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef logic owner_t;
    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_VID = 1'b1;

    // Lane 0 carries bits 7:0 of the RAM word.
    function automatic logic [3:0] lane_onehot(input logic [1:0] adr);
        return 4'b0001 << adr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_if
// Brief    : CPU, video-fetch, SRAM and statistics bundle around mem_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic              cpu_en;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              cpu_ben;
    logic [19:0]       cpu_adr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              memwait;

    logic              vid_req;
    logic [RAM_AW-1:0] vid_adr;
    logic              vid_ack;
    logic [31:0]       vid_rdata;

    logic              ram_ce;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [RAM_AW-1:0] ram_adr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       stat_cpu_wait;
    logic [31:0]       stat_vid_grant;

    modport slave (
        input  cpu_en, cpu_rd, cpu_wr, cpu_ben, cpu_adr, cpu_wdata,
        output cpu_rdata, memwait,
        input  vid_req, vid_adr,
        output vid_ack, vid_rdata,
        output ram_ce, ram_we, ram_be, ram_adr, ram_wdata,
        input  ram_rdata,
        output stat_cpu_wait, stat_vid_grant
    );

    modport master (
        output cpu_en, cpu_rd, cpu_wr, cpu_ben, cpu_adr, cpu_wdata,
        input  cpu_rdata, memwait,
        output vid_req, vid_adr,
        input  vid_ack, vid_rdata,
        input  ram_ce, ram_we, ram_be, ram_adr, ram_wdata,
        output ram_rdata,
        input  stat_cpu_wait, stat_vid_grant
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_lane
// Brief    : Byte-lane steering of CPU write data and lane enables.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_lane
    import mem_arb_pkg::*;
(
    input  logic        i_ben,
    input  logic [1:0]  i_adr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    assign o_be = i_ben ? lane_onehot(i_adr) : BE_WORD;

    // A byte store puts the low byte on every lane; o_be selects the live one.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign o_wdata[8*i +: 8] = i_ben ? i_wdata[7:0] : i_wdata[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Brief    : Main-RAM arbiter between CPU port and video refresh fetch.
//            Define MEM_ARB_STATS_EN to build the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ACC_CYC = 2,
    parameter int VID_MAX = 4
)(
    input  logic      clk,
    input  logic      rst_n,
    mem_arb_if.slave  bus
);

    localparam int         c_sw       = (VID_MAX < 2) ? 1 : $clog2(VID_MAX + 1);
    localparam logic [3:0] c_last_cyc = 4'(ACC_CYC - 1);
    localparam logic [c_sw-1:0] c_vid_max = c_sw'(VID_MAX);

    state_t            r_state;
    owner_t            r_owner;
    logic [3:0]        r_cnt;
    logic [c_sw-1:0]   r_streak;
    logic              r_ram_ce;
    logic              r_ram_we;
    logic [3:0]        r_ram_be;
    logic [RAM_AW-1:0] r_ram_adr;
    logic [31:0]       r_ram_wdata;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_vid_rdata;
    logic              r_vid_ack;

    logic              w_cpu_req;
    logic              w_memwait;
    logic              w_vid_grant;
    logic              w_cpu_grant;
    logic [3:0]        w_lane_be;
    logic [31:0]       w_lane_wdata;

    assign w_cpu_req   = bus.cpu_en & (bus.cpu_rd | bus.cpu_wr);
    assign w_memwait   = w_cpu_req & ~((r_state == DONE) & (r_owner == OWN_CPU));
    // Video wins ties until it has taken VID_MAX grants in a row over a waiting CPU.
    assign w_vid_grant = (r_state == IDLE) & bus.vid_req &
                         (~w_cpu_req | (r_streak < c_vid_max));
    assign w_cpu_grant = (r_state == IDLE) & ~w_vid_grant & w_cpu_req;

    mem_arb_lane u_lane (
        .i_ben   (bus.cpu_ben & bus.cpu_wr),
        .i_adr   (bus.cpu_adr[1:0]),
        .i_wdata (bus.cpu_wdata),
        .o_be    (w_lane_be),
        .o_wdata (w_lane_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_cnt       <= 4'd0;
            r_streak    <= '0;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= 4'h0;
            r_ram_adr   <= '0;
            r_ram_wdata <= 32'h0;
            r_cpu_rdata <= 32'h0;
            r_vid_rdata <= 32'h0;
            r_vid_ack   <= 1'b0;
        end else begin
            r_vid_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_vid_grant) begin
                        r_state     <= ACC;
                        r_owner     <= OWN_VID;
                        r_cnt       <= 4'd0;
                        r_streak    <= r_streak + c_sw'(w_cpu_req);
                        r_ram_ce    <= 1'b1;
                        r_ram_we    <= 1'b0;
                        r_ram_be    <= BE_WORD;
                        r_ram_adr   <= bus.vid_adr;
                        r_ram_wdata <= 32'h0;
                    end else if (w_cpu_grant) begin
                        r_state     <= ACC;
                        r_owner     <= OWN_CPU;
                        r_cnt       <= 4'd0;
                        r_streak    <= '0;
                        r_ram_ce    <= 1'b1;
                        r_ram_we    <= bus.cpu_wr;
                        r_ram_be    <= w_lane_be;
                        r_ram_adr   <= bus.cpu_adr[19:2];
                        r_ram_wdata <= w_lane_wdata;
                    end
                end
                ACC: begin
                    if (r_cnt == c_last_cyc) begin
                        r_state  <= DONE;
                        r_ram_ce <= 1'b0;
                        r_ram_we <= 1'b0;
                        r_ram_be <= 4'h0;
                        if (r_owner == OWN_CPU) begin
                            r_cpu_rdata <= bus.ram_rdata;
                        end else begin
                            r_vid_rdata <= bus.ram_rdata;
                            r_vid_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.memwait   = w_memwait;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.vid_ack   = r_vid_ack;
    assign bus.vid_rdata = r_vid_rdata;
    assign bus.ram_ce    = r_ram_ce;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_be    = r_ram_be;
    assign bus.ram_adr   = r_ram_adr;
    assign bus.ram_wdata = r_ram_wdata;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_cpu_wait;
    logic [31:0] r_stat_vid_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cpu_wait  <= 32'h0;
            r_stat_vid_grant <= 32'h0;
        end else begin
            if (w_memwait)   r_stat_cpu_wait  <= r_stat_cpu_wait + 32'd1;
            if (w_vid_grant) r_stat_vid_grant <= r_stat_vid_grant + 32'd1;
        end
    end

    assign bus.stat_cpu_wait  = r_stat_cpu_wait;
    assign bus.stat_vid_grant = r_stat_vid_grant;
`else
    assign bus.stat_cpu_wait  = 32'h0;
    assign bus.stat_vid_grant = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb
// Brief    : Scoreboard bench for mem_arb with a behavioural SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int ACC_CYC = 2;
    localparam int VID_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus();

    mem_arb #(.ACC_CYC(ACC_CYC), .VID_MAX(VID_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM model: word k preloads to C0DE_0000 | k, except word 0x41.
    logic [31:0] mem [0:255];
    assign bus.ram_rdata = mem[bus.ram_adr[7:0]];

    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.ram_ce && bus.ram_we) begin
            w = mem[bus.ram_adr[7:0]];
            for (int l = 0; l < 4; l++)
                if (bus.ram_be[l]) w[8*l +: 8] = bus.ram_wdata[8*l +: 8];
            mem[bus.ram_adr[7:0]] <= w;
        end
    end

    typedef struct { owner_t own; logic [31:0] data; logic chk; } rsp_t;
    typedef struct { logic [17:0] adr; logic we; logic [3:0] be; logic [31:0] wdata; } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   mw_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_acc(input logic [17:0] adr, input logic we, input logic [3:0] be,
                            input logic [31:0] wd);
        acc_t a;
        a.adr = adr; a.we = we; a.be = be; a.wdata = wd;
        acc_q.push_back(a);
    endtask

    task automatic push_rsp(input owner_t own, input logic [31:0] data, input logic c);
        rsp_t r;
        r.own = own; r.data = data; r.chk = c;
        rsp_q.push_back(r);
    endtask

    // Monitor: RAM-side accesses and completions are checked against the queues.
    logic prev_ce = 1'b0;
    int   ce_len  = 0;
    acc_t cur_a;
    always @(negedge clk) begin
        rsp_t r;
        if (!rst_n) begin
            prev_ce  = 1'b0;
            ce_len   = 0;
            mw_total = 0;
        end else begin
            if (bus.memwait) mw_total++;
            if (bus.ram_ce) begin
                if (!prev_ce) begin
                    chk("acc_pending", 32'(acc_q.size() > 0), 32'd1);
                    if (acc_q.size() > 0) cur_a = acc_q.pop_front();
                end
                chk("ram_adr", 32'(bus.ram_adr), 32'(cur_a.adr));
                chk("ram_we",  32'(bus.ram_we),  32'(cur_a.we));
                chk("ram_be",  32'(bus.ram_be),  32'(cur_a.be));
                if (cur_a.we) chk("ram_wdata", bus.ram_wdata, cur_a.wdata);
                ce_len++;
            end else if (prev_ce) begin
                chk("acc_len", 32'(ce_len), 32'(ACC_CYC));
                ce_len = 0;
            end
            prev_ce = bus.ram_ce;

            if (bus.vid_ack) begin
                chk("rsp_pending_vid", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    chk("owner_vid", 32'(OWN_VID), 32'(r.own));
                    if (r.chk) chk("vid_rdata", bus.vid_rdata, r.data);
                end
            end
            if (bus.cpu_en && (bus.cpu_rd || bus.cpu_wr) && !bus.memwait) begin
                chk("rsp_pending_cpu", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    chk("owner_cpu", 32'(OWN_CPU), 32'(r.own));
                    if (r.chk) chk("cpu_rdata", bus.cpu_rdata, r.data);
                end
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic ben, input logic [19:0] adr,
                          input logic [31:0] wd, input int exp_mw, input string name);
        int   mw  = 0;
        int   cyc = 0;
        logic fin = 1'b0;
        @(posedge clk); #1;
        bus.cpu_en = 1'b1; bus.cpu_rd = ~wr; bus.cpu_wr = wr;
        bus.cpu_ben = ben; bus.cpu_adr = adr; bus.cpu_wdata = wd;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.memwait) mw++;
            else fin = 1'b1;
        end
        chk({name, "_served"}, 32'(fin), 32'd1);
        chk({name, "_memwait_cycles"}, 32'(mw), 32'(exp_mw));
        @(posedge clk); #1;
        bus.cpu_en = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    endtask

    task automatic vid_run(input logic [17:0] adr, input int n);
        int k   = 0;
        int cyc = 0;
        @(posedge clk); #1;
        bus.vid_adr = adr; bus.vid_req = 1'b1;
        while (k < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.vid_ack) k++;
        end
        chk("vid_ack_count", 32'(k), 32'(n));
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ram_ce"},    32'(bus.ram_ce),  32'd0);
        chk({tag, "_ram_we"},    32'(bus.ram_we),  32'd0);
        chk({tag, "_ram_be"},    32'(bus.ram_be),  32'd0);
        chk({tag, "_ram_adr"},   32'(bus.ram_adr), 32'd0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata,    32'd0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata,    32'd0);
        chk({tag, "_vid_rdata"}, bus.vid_rdata,    32'd0);
        chk({tag, "_vid_ack"},   32'(bus.vid_ack), 32'd0);
        chk({tag, "_memwait"},   32'(bus.memwait), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[8'h41] = 32'hDEAD_BEEF;

        bus.cpu_en = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_ben = 1'b0;
        bus.cpu_adr = 20'h0; bus.cpu_wdata = 32'h0; bus.vid_req = 1'b0; bus.vid_adr = 18'h0;

        // memwait is combinational even while held in reset
        repeat (2) @(posedge clk);
        #1 bus.cpu_en = 1'b1; bus.cpu_rd = 1'b1;
        #1 chk("rst_memwait_req", 32'(bus.memwait), 32'd1);
        bus.cpu_en = 1'b0; bus.cpu_rd = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");

        // Reset asserted in the middle of a video access
        push_acc(18'h00011, 1'b0, 4'hF, 32'h0);
        @(posedge clk); #1 bus.vid_adr = 18'h00011; bus.vid_req = 1'b1;
        @(posedge clk); #1 bus.vid_req = 1'b0;
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk("midrst_ce_immediate", 32'(bus.ram_ce), 32'd0);
        chk("midrst_no_ack", 32'(bus.vid_ack), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_vals("midrst");

        // CPU word read, byte/word writes, read-backs
        push_acc(18'h00041, 1'b0, 4'hF, 32'h0);
        push_rsp(OWN_CPU, 32'hDEAD_BEEF, 1'b1);
        cpu_op(1'b0, 1'b0, 20'h00104, 32'h0, 3, "rd41");

        push_acc(18'h00004, 1'b1, 4'b1000, 32'hA5A5_A5A5);
        push_rsp(OWN_CPU, 32'h0, 1'b0);
        cpu_op(1'b1, 1'b1, 20'h00013, 32'h0000_00A5, 3, "wrb13");

        push_acc(18'h00004, 1'b0, 4'hF, 32'h0);
        push_rsp(OWN_CPU, 32'hA5DE_0004, 1'b1);
        cpu_op(1'b0, 1'b0, 20'h00010, 32'h0, 3, "rd10");

        push_acc(18'h00008, 1'b1, 4'hF, 32'h1234_5678);
        push_rsp(OWN_CPU, 32'h0, 1'b0);
        cpu_op(1'b1, 1'b0, 20'h00020, 32'h1234_5678, 3, "wrw20");

        push_acc(18'h00008, 1'b1, 4'b0010, 32'h5A5A_5A5A);
        push_rsp(OWN_CPU, 32'h0, 1'b0);
        cpu_op(1'b1, 1'b1, 20'h00021, 32'hFFFF_FF5A, 3, "wrb21");

        push_acc(18'h00008, 1'b0, 4'hF, 32'h0);
        push_rsp(OWN_CPU, 32'h1234_5A78, 1'b1);
        cpu_op(1'b0, 1'b0, 20'h00020, 32'h0, 3, "rd20");

        // Simultaneous requests with streak 0: video first, then CPU
        push_acc(18'h00010, 1'b0, 4'hF, 32'h0);
        push_acc(18'h00041, 1'b0, 4'hF, 32'h0);
        push_rsp(OWN_VID, 32'hC0DE_0010, 1'b1);
        push_rsp(OWN_CPU, 32'hDEAD_BEEF, 1'b1);
        fork
            vid_run(18'h00010, 1);
            cpu_op(1'b0, 1'b0, 20'h00104, 32'h0, 7, "contend");
        join

        // Continuous video: four grants, then CPU, then video resumes
        for (int i = 0; i < 4; i++) push_acc(18'h00030, 1'b0, 4'hF, 32'h0);
        push_acc(18'h00041, 1'b0, 4'hF, 32'h0);
        push_acc(18'h00030, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) push_rsp(OWN_VID, 32'hC0DE_0030, 1'b1);
        push_rsp(OWN_CPU, 32'hDEAD_BEEF, 1'b1);
        push_rsp(OWN_VID, 32'hC0DE_0030, 1'b1);
        fork
            vid_run(18'h00030, 5);
            cpu_op(1'b0, 1'b0, 20'h00104, 32'h0, 19, "fair");
        join

        // Statistics window: fresh reset, 10 fetches and one contended read
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_acc(18'h00022, 1'b0, 4'hF, 32'h0);
        push_acc(18'h00004, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) push_acc(18'h00022, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) push_rsp(OWN_VID, 32'hC0DE_0022, 1'b1);
        push_rsp(OWN_CPU, 32'hA5DE_0004, 1'b1);
        for (int i = 0; i < 6; i++) push_rsp(OWN_VID, 32'hC0DE_0022, 1'b1);
        fork
            vid_run(18'h00022, 10);
            cpu_op(1'b0, 1'b0, 20'h00010, 32'h0, 19, "stats");
        join
        repeat (3) @(negedge clk);
        chk("mw_total", 32'(mw_total), 32'd19);
`ifdef MEM_ARB_STATS_EN
        chk("stat_vid_grant", bus.stat_vid_grant, 32'd10);
        chk("stat_cpu_wait",  bus.stat_cpu_wait,  32'(mw_total));
`else
        chk("stat_vid_grant", bus.stat_vid_grant, 32'd0);
        chk("stat_cpu_wait",  bus.stat_cpu_wait,  32'd0);
`endif

        chk("acc_q_empty", 32'(acc_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
